// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//   Table of 2-bit saturating counters indexed by PC. It answers fetch
//   lookups one cycle later and resolves executed branches into a 2-bit code
//   for the flush generator (2'b10 = mispredict/redirect). After a
//   mispredict, lookups are held off while the downstream flush walk runs.
//
// Optional feature macro: BP_GSHARE_EN
//   When defined, a global history register is XORed into the table index.
//   When undefined, index = pc[INDEX_W+1:2].
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   lookup_valid_i      fetch requests a prediction
//   lookup_pc_i         PC of the fetched instruction
//   pred_valid_o        registered: prediction for last cycle's lookup valid
//   pred_taken_o        registered: predicted direction (counter MSB)
//   resolve_valid_i     execute resolves a branch this cycle
//   resolve_pc_i        PC of the resolved branch
//   resolve_taken_i     actual outcome
//   resolve_pred_i      direction that was predicted for this branch
//   pred                registered resolve code: 00 none, 01/11 correct, 10 mispredict
//   busy_o              high during the redirect walk; lookups ignored
// ---------------------------------------------------------------------------
module branch_predictor #(
  parameter int PC_W         = 32,
  parameter int INDEX_W      = 6,
  parameter int REDIRECT_CYC = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            lookup_valid_i,
  input  logic [PC_W-1:0] lookup_pc_i,
  output logic            pred_valid_o,
  output logic            pred_taken_o,
  input  logic            resolve_valid_i,
  input  logic [PC_W-1:0] resolve_pc_i,
  input  logic            resolve_taken_i,
  input  logic            resolve_pred_i,
  output logic [1:0]      pred,
  output logic            busy_o
);

  localparam int ENTRIES = 1 << INDEX_W;
  localparam int RC_W    = $clog2(REDIRECT_CYC + 1);

  typedef enum logic {IDLE, REDIRECT} state_t;

  // Saturating 2-bit counter step; arithmetic kept at 2 bits.
  function automatic logic [1:0] cnt_next(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'b01;
    else       return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  // Resolve code: {outcome,1} when the prediction matched, 10 otherwise.
  function automatic logic [1:0] resolve_code(input logic vld, input logic taken,
                                              input logic predicted);
    if (!vld)                    return 2'b00;
    else if (taken == predicted) return {taken, 1'b1};
    else                         return 2'b10;
  endfunction

  logic [1:0]         table_q [ENTRIES];
  logic [INDEX_W-1:0] lookup_idx;
  logic [INDEX_W-1:0] res_idx;
  logic [1:0]         res_cnt_nxt;
  logic [1:0]         lk_cnt;
  logic               mispredict;
  state_t             state_q, state_d;
  logic [RC_W-1:0]    rc_q, rc_d;

  // Only the index bits of the PCs are used by the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc_i[PC_W-1:INDEX_W+2], lookup_pc_i[1:0],
                            resolve_pc_i[PC_W-1:INDEX_W+2], resolve_pc_i[1:0]};

`ifdef BP_GSHARE_EN
  logic [INDEX_W-1:0] ghr_q;

  // Both paths see the history before this cycle's shift.
  assign lookup_idx = lookup_pc_i[INDEX_W+1:2] ^ ghr_q;
  assign res_idx    = resolve_pc_i[INDEX_W+1:2] ^ ghr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)                ghr_q <= '0;
    else if (resolve_valid_i) ghr_q <= {ghr_q[INDEX_W-2:0], resolve_taken_i};
  end
`else
  assign lookup_idx = lookup_pc_i[INDEX_W+1:2];
  assign res_idx    = resolve_pc_i[INDEX_W+1:2];
`endif

  assign res_cnt_nxt = cnt_next(table_q[res_idx], resolve_taken_i);
  assign mispredict  = resolve_valid_i && (resolve_taken_i != resolve_pred_i);

  // Write-through: a lookup colliding with this cycle's update sees the new value.
  assign lk_cnt = (resolve_valid_i && (res_idx == lookup_idx)) ? res_cnt_nxt
                                                               : table_q[lookup_idx];

  // ---- counter table update (written at the clock edge) ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= 2'b01;
    end else if (resolve_valid_i) begin
      table_q[res_idx] <= res_cnt_nxt;
    end
  end

  // ---- stage 1: lookup response and resolve code ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pred_valid_o <= 1'b0;
      pred_taken_o <= 1'b0;
      pred         <= 2'b00;
    end else begin
      pred_valid_o <= lookup_valid_i && !busy_o;
      if (lookup_valid_i && !busy_o) pred_taken_o <= lk_cnt[1];
      pred <= resolve_code(resolve_valid_i, resolve_taken_i, resolve_pred_i);
    end
  end

  // ---- redirect FSM ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rc_q    <= '0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    case (state_q)
      IDLE: begin
        if (mispredict) begin
          state_d = REDIRECT;
          rc_d    = RC_W'(REDIRECT_CYC);
        end
      end
      REDIRECT: begin
        // A further mispredict restarts the walk from the top.
        if (mispredict) begin
          rc_d = RC_W'(REDIRECT_CYC);
        end else if (rc_q == RC_W'(1)) begin
          state_d = IDLE;
          rc_d    = '0;
        end else begin
          rc_d = rc_q - RC_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        rc_d    = '0;
      end
    endcase
  end

  assign busy_o = (state_q == REDIRECT);

endmodule

// File: tb/tb_branch_predictor.sv
`timescale 1ns/1ps
module tb_branch_predictor;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        lookup_valid_i;
  logic [31:0] lookup_pc_i;
  logic        pred_valid_o;
  logic        pred_taken_o;
  logic        resolve_valid_i;
  logic [31:0] resolve_pc_i;
  logic        resolve_taken_i;
  logic        resolve_pred_i;
  logic [1:0]  pred;
  logic        busy_o;

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  logic      exp_taken_q [$];
  logic [1:0] exp_code_q [$];
  int        exp_busy_q [$];
  int        busy_run = 0;

  branch_predictor #(.PC_W(32), .INDEX_W(6), .REDIRECT_CYC(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .lookup_valid_i(lookup_valid_i), .lookup_pc_i(lookup_pc_i),
    .pred_valid_o(pred_valid_o), .pred_taken_o(pred_taken_o),
    .resolve_valid_i(resolve_valid_i), .resolve_pc_i(resolve_pc_i),
    .resolve_taken_i(resolve_taken_i), .resolve_pred_i(resolve_pred_i),
    .pred(pred), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an output.
  always @(negedge clk_i) begin
    if (started) begin
      if (pred_valid_o === 1'b1) begin
        if (exp_taken_q.size() == 0) check("unexpected_pred_valid", 1, 0);
        else check("pred_taken", int'(pred_taken_o), int'(exp_taken_q.pop_front()));
      end
      if (pred !== 2'b00) begin
        if (exp_code_q.size() == 0) check("unexpected_pred_code", int'(pred), 0);
        else check("pred_code", int'(pred), int'(exp_code_q.pop_front()));
      end
      if (busy_o === 1'b1) begin
        busy_run++;
      end else if (busy_run > 0) begin
        if (exp_busy_q.size() == 0) check("unexpected_busy_run", busy_run, 0);
        else check("busy_run_len", busy_run, exp_busy_q.pop_front());
        busy_run = 0;
      end
    end
  end

  task automatic cyc(input logic lv, input logic [31:0] lpc, input logic rv,
                     input logic [31:0] rpc, input logic rt, input logic rp);
    lookup_valid_i  = lv;
    lookup_pc_i     = lpc;
    resolve_valid_i = rv;
    resolve_pc_i    = rpc;
    resolve_taken_i = rt;
    resolve_pred_i  = rp;
    @(posedge clk_i);
    #1;
    lookup_valid_i  = 1'b0;
    lookup_pc_i     = '0;
    resolve_valid_i = 1'b0;
    resolve_pc_i    = '0;
    resolve_taken_i = 1'b0;
    resolve_pred_i  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_i = 1'b1;
    idle(2);
    rst_i = 1'b0;
    check("rst_pred_valid", int'(pred_valid_o), 0);
    check("rst_pred_taken", int'(pred_taken_o), 0);
    check("rst_pred_code",  int'(pred), 0);
    check("rst_busy",       int'(busy_o), 0);
    started = 1'b1;

    // Fresh counter (01) predicts not-taken.
    exp_taken_q.push_back(1'b0);
    cyc(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
    idle(1);

    // Collision on idx 0: counter 01 -> 10, lookup sees the bypassed MSB.
    exp_taken_q.push_back(1'b1);
    exp_code_q.push_back(2'b11);
    cyc(1'b1, 32'h200, 1'b1, 32'h200, 1'b1, 1'b1);
    idle(1);

    // Mispredict on 0x100 (idx 0: 10 -> 11); five busy cycles swallow lookups.
    exp_code_q.push_back(2'b10);
    exp_busy_q.push_back(5);
    cyc(1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
    exp_taken_q.push_back(1'b1);
    cyc(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
    idle(1);

    // 0x104 taken three times: 01->10->11->11.
    exp_code_q.push_back(2'b10);
    exp_code_q.push_back(2'b11);
    exp_code_q.push_back(2'b11);
    exp_busy_q.push_back(5);
    cyc(1'b0, 32'h0, 1'b1, 32'h104, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 32'h104, 1'b1, 1'b1);
    cyc(1'b0, 32'h0, 1'b1, 32'h104, 1'b1, 1'b1);
    idle(4);
    exp_taken_q.push_back(1'b1);
    cyc(1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 1'b0);
    idle(1);

    // Second mispredict three cycles after the first: busy 3 + 5 = 8.
    exp_code_q.push_back(2'b10);
    exp_code_q.push_back(2'b10);
    exp_busy_q.push_back(8);
    cyc(1'b0, 32'h0, 1'b1, 32'h108, 1'b1, 1'b0);
    idle(2);
    cyc(1'b0, 32'h0, 1'b1, 32'h108, 1'b1, 1'b0);
    idle(6);

    // Reset during the walk aborts it and restores the table.
    exp_code_q.push_back(2'b10);
    exp_busy_q.push_back(2);
    cyc(1'b0, 32'h0, 1'b1, 32'h104, 1'b0, 1'b1);
    idle(1);
    rst_i = 1'b1;
    idle(1);
    rst_i = 1'b0;
    check("post_rst_busy", int'(busy_o), 0);
    check("post_rst_code", int'(pred), 0);
    exp_taken_q.push_back(1'b0);
    cyc(1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 1'b0);
    idle(3);

    check("left_pred_expect", exp_taken_q.size(), 0);
    check("left_code_expect", exp_code_q.size(), 0);
    check("left_busy_expect", exp_busy_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
